// File: rtl/stream_sender_receiver.sv
// Single-clock stream pair: an LFSR-paced sender of an incrementing sequence and
// a receiver that tracks the next expected value and latches any mismatch.
module stream_sender_receiver #(
  parameter int          DATA_W    = 4,
  parameter int          GAP_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GAP_W-1:0]  gap_from,
  input  logic [GAP_W-1:0]  gap_to,
  input  logic              inject_err,
  output logic [DATA_W-1:0] data,
  output logic              en,
  output logic [DATA_W-1:0] expected,
  output logic              failure
);

  // Handshake: en is a one-cycle valid strobe qualifying data; the receiver has
  // no backpressure and consumes every cycle in which en is high.

  logic [15:0]       lfsr;
  logic [DATA_W-1:0] seq;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_sel;
  logic [GAP_W:0]    rnd_ext;
  logic [GAP_W:0]    span;
  logic [GAP_W:0]    offset;
  logic [GAP_W:0]    gap_sum;
  logic              lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Pick the next idle length in [gap_from, gap_to]; an inverted range pins it to gap_from.
  always_comb begin
    rnd_ext = (GAP_W+1)'(lfsr[7:0]);
    span    = '0;
    offset  = '0;
    gap_sum = '0;
    gap_sel = gap_from;
    if (gap_to > gap_from) begin
      span    = {1'b0, gap_to} - {1'b0, gap_from} + (GAP_W+1)'(1);
      offset  = rnd_ext % span;
      gap_sum = {1'b0, gap_from} + offset;
      gap_sel = gap_sum[GAP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en      <= 1'b0;
      data    <= '0;
      seq     <= '0;
      gap_cnt <= '0;
    end else if (gap_cnt == '0) begin
      en      <= 1'b1;
      data    <= seq;
      seq     <= seq + (inject_err ? DATA_W'(2) : DATA_W'(1));
      gap_cnt <= gap_sel;
    end else begin
      en      <= 1'b0;
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Receiver resynchronises to each observed value so a single skip flags once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expected <= '0;
      failure  <= 1'b0;
    end else if (en) begin
      if (data != expected) failure <= 1'b1;
      expected <= data + DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_sender_receiver.sv
// Directed bench for stream_sender_receiver: vector tables for fixed gaps plus
// hand sequences for random gaps, error injection and asynchronous reset.
module tb_stream_sender_receiver;

  logic       clk;
  logic       rst;
  logic [7:0] gap_from;
  logic [7:0] gap_to;
  logic       inject_err;
  logic [3:0] data;
  logic       en;
  logic [3:0] expected;
  logic       failure;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [3:0] data;
    logic [3:0] expected;
    logic       failure;
  } vec_t;

  vec_t tbl[30];

  stream_sender_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .gap_from   (gap_from),
    .gap_to     (gap_to),
    .inject_err (inject_err),
    .data       (data),
    .en         (en),
    .expected   (expected),
    .failure    (failure)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected range [%0d,%0d] (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Assert reset for a cycle, check cleared outputs, release on a falling edge
  // so the next rising edge is the first one out of reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_en", en, 0);
    check("rst_data", data, 0);
    check("rst_expected", expected, 0);
    check("rst_failure", failure, 0);
    rst = 1'b1;
  endtask

  task automatic run_table(input string name);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_en"}, en, tbl[k].en);
      check({name, "_data"}, data, tbl[k].data);
      check({name, "_expected"}, expected, tbl[k].expected);
      check({name, "_failure"}, failure, tbl[k].failure);
    end
  endtask

  // Measure idle runs and sequence continuity under a gap range.
  task automatic run_gap_phase(input string name, input int from, input int to,
                               input int lo, input int hi, input int ncyc);
    int         run;
    int         strobes;
    logic       prev_en;
    logic [3:0] prev_data;
    logic [3:0] last_strobe;
    logic [3:0] nxt;
    gap_from = 8'(from);
    gap_to   = 8'(to);
    do_reset();
    run = 0;
    strobes = 0;
    prev_en = 1'b0;
    prev_data = '0;
    last_strobe = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (prev_en) begin
        nxt = prev_data + 4'd1;
        check({name, "_exp_follow"}, expected, nxt);
      end
      if (en) begin
        if (strobes == 0) begin
          check({name, "_first_data"}, data, 0);
          check({name, "_first_cycle"}, c, 0);
        end else begin
          nxt = last_strobe + 4'd1;
          check({name, "_contig"}, data, nxt);
          check_range({name, "_idle_run"}, run, lo, hi);
        end
        strobes++;
        run = 0;
        last_strobe = data;
      end else begin
        run++;
      end
      prev_en = en;
      prev_data = data;
    end
    check({name, "_failure"}, failure, 0);
    check_range({name, "_strobes"}, strobes, ncyc / (hi + 1) - 1, ncyc);
  endtask

  initial begin
    rst        = 1'b0;
    gap_from   = '0;
    gap_to     = '0;
    inject_err = 1'b0;

    // Slow: period 6, data 0,1,2,... ; expected catches up the cycle after each strobe
    for (int i = 0; i < 30; i++) begin
      tbl[i].en       = (i % 6 == 0);
      tbl[i].data     = 4'(i / 6);
      tbl[i].expected = (i % 6 == 0) ? 4'(i / 6) : 4'(i / 6 + 1);
      tbl[i].failure  = 1'b0;
    end
    gap_from = 8'd5;
    gap_to   = 8'd5;
    do_reset();
    run_table("slow");

    // Fast: strobe every cycle, data wraps 15 -> 0, expected one cycle behind +1
    for (int i = 0; i < 30; i++) begin
      tbl[i].en       = 1'b1;
      tbl[i].data     = 4'(i % 16);
      tbl[i].expected = 4'(i % 16);
      tbl[i].failure  = 1'b0;
    end
    gap_from = 8'd0;
    gap_to   = 8'd0;
    do_reset();
    run_table("fast");

    run_gap_phase("rand", 0, 10, 0, 10, 200);
    run_gap_phase("band", 3, 6, 3, 6, 150);
    run_gap_phase("inv", 7, 3, 7, 7, 60);

    // Error injection with gap 2: strobe s lands on rising edge 1+3s, data=4 on edge 13
    gap_from = 8'd2;
    gap_to   = 8'd2;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      inject_err = (k == 13);
      @(posedge clk);
      @(negedge clk);
      inject_err = 1'b0;
      case (k)
        13: begin check("inj_en13", en, 1); check("inj_data13", data, 4); end
        14: begin check("inj_exp14", expected, 5); check("inj_fail14", failure, 0); end
        16: begin
          check("inj_en16", en, 1);
          check("inj_data16", data, 6);
          check("inj_fail16", failure, 0);
        end
        17: begin check("inj_fail17", failure, 1); check("inj_exp17", expected, 7); end
        19: begin check("inj_data19", data, 7); check("inj_fail19", failure, 1); end
        20: check("inj_exp20", expected, 8);
        22: check("inj_data22", data, 8);
        30: check("inj_fail_sticky", failure, 1);
        default: ;
      endcase
    end

    // Reset mid-run: outputs must clear between clock edges
    gap_from = 8'd0;
    gap_to   = 8'd10;
    do_reset();
    repeat (37) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_en", en, 0);
    check("async_data", data, 0);
    check("async_expected", expected, 0);
    check("async_failure", failure, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_en", en, 1);
    check("restart_data", data, 0);
    check("restart_expected", expected, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("restart_failure", failure, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_sender_receiver.md
Name: stream_sender_receiver

Overview:
- Self-checking stream pair on one clock.
- The sender half emits an incrementing 4-bit sequence with a one-cycle valid strobe. The gap between strobes is pseudo-random within a programmable range.
- The receiver half consumes the strobe and data directly and tracks the value it expects next. It raises a sticky failure flag on any mismatch.
- Used as the single-clock baseline for the CDC lab: throughput and gap stress against the same checker.

Parameters:
- DATA_W, 4, width of data and expected.
- GAP_W, 8, width of gap_from and gap_to.
- LFSR_SEED, 16'hACE1, non-zero reset value of the gap LFSR.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = in reset)
- gap_from  input  GAP_W  minimum idle cycles between transfers
- gap_to  input  GAP_W  maximum idle cycles between transfers
- inject_err  input  1  when high on a transfer cycle, the sender skips one sequence value
- data  output  DATA_W  sender payload; valid when en=1
- en  output  1  sender valid strobe, one cycle per transfer
- expected  output  DATA_W  receiver's next expected value
- failure  output  1  sticky mismatch flag

Behaviour:
- All outputs and state are registered, cleared asynchronously while rst=0: data=0, en=0, expected=0, failure=0, seq=0, gap_cnt=0, lfsr=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle out of reset. rnd = lfsr[7:0].
- Gap selection:
  - If gap_to <= gap_from: g = gap_from.
  - Otherwise: g = gap_from + (rnd mod (gap_to - gap_from + 1)), computed at 9 bits.
  - Result always lies in [gap_from, gap_to].
- Sender, at each posedge:
  - gap_cnt == 0: en<=1; data<=seq; seq<=seq+1 (or seq+2 if inject_err=1); gap_cnt<=g.
  - Otherwise: en<=0; gap_cnt<=gap_cnt-1; data holds its last value.
- Timing consequences:
  - The first strobe occurs on the first posedge after rst rises.
  - g=0 gives en continuously high, with data incrementing every cycle.
  - g=N gives en high 1 cycle, then low N cycles (period N+1).
- seq/data wrap modulo 2^DATA_W (15 -> 0). Wrap is not an error.
- gap_from/gap_to are sampled only on transfer cycles. A change takes effect from the next gap; the current countdown is not disturbed.
- Receiver, at each posedge with en=1:
  - If data != expected: failure<=1.
  - expected<=data+1 (modulo 2^DATA_W). This resynchronises so a single skip flags once.
- With en=0 the receiver holds its state.
- failure is sticky; only reset clears it.
- Latency: failure rises on the posedge after the bad strobe cycle (receiver samples registered sender outputs).
- Reset asserted mid-transfer clears everything immediately. Operation restarts from data 0 after release with no spurious failure.

Test Plan:
- Slow (gap_from=gap_to=5), 30 cycles after reset:
  - en pulses 1 cycle every 6 cycles.
  - data = 0,1,2,3,4 on successive strobes.
  - expected tracks data+1; failure=0.
- Fast (gap_from=gap_to=0), 30 cycles:
  - en constantly 1; data increments every cycle and wraps 15->0.
  - expected = data+1 one cycle later; failure=0.
- Random (gap_from=0, gap_to=10), 30+ cycles:
  - Every measured idle run between strobes is in [0,10].
  - Sequence is contiguous; failure=0.
- Inverted range (gap_from=7, gap_to=3):
  - Every idle run is exactly 7 cycles; failure=0.
- Error injection:
  - Pulse inject_err on the strobe carrying data=4; next strobe carries 6.
  - failure=1 one cycle after that strobe and stays 1.
  - Subsequent strobes (7,8,...) match expected without further effect.
- Reset mid-run:
  - Drop rst during a random-gap run: data, en, expected and failure go to 0 without waiting for clk.
  - After release, the first strobe carries data=0; failure stays 0.
